// File: rtl/video_bank_reader.sv
// Display-side reader for the ping-pong video banks.
// Generates VGA timing from the pixel clock, fetches packed 1bpp words from the
// latched bank and draws them centred in the active area. Counter-to-pin latency
// is two cycles for sync and colour alike.
module video_bank_reader #(
   parameter int IMG_W        = 480,
   parameter int IMG_H        = 360,
   parameter int IMG_X0       = 160,
   parameter int IMG_Y0       = 120,
   parameter int FRAME_REPEAT = 2,
   parameter int ADDR_W       = 15,
   parameter int H_ACTIVE     = 800,
   parameter int H_FP         = 40,
   parameter int H_SYNC       = 128,
   parameter int H_BP         = 88,
   parameter int V_ACTIVE     = 600,
   parameter int V_FP         = 1,
   parameter int V_SYNC       = 4,
   parameter int V_BP         = 23
) (
   input  logic              CLK_40,
   input  logic              reset,
   input  logic              read_bank1,
   input  logic              read_bank2,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [7:0]        rd_data1,
   input  logic [7:0]        rd_data2,
   output logic              hsync,
   output logic              vsync,
   output logic [3:0]        vga_r,
   output logic [3:0]        vga_g,
   output logic [3:0]        vga_b,
   output logic              bank1_read_done,
   output logic              bank2_read_done
);

   // state  | meaning
   // IDLE   | no bank latched, frame drawn black
   // SHOW1  | bank 1 latched, counting refreshes
   // SHOW2  | bank 2 latched, counting refreshes
   typedef enum logic [1:0] {IDLE, SHOW1, SHOW2} state_t;

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);

   localparam logic [HW-1:0]     H_LAST    = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0]     H_SYNC_S  = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0]     H_SYNC_E  = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [HW-1:0]     IMG_XS    = HW'(IMG_X0);
   localparam logic [HW-1:0]     IMG_XE    = HW'(IMG_X0 + IMG_W);
   localparam logic [VW-1:0]     V_LAST    = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0]     V_SYNC_S  = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0]     V_SYNC_E  = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [VW-1:0]     V_ACT_END = VW'(V_ACTIVE - 1);
   localparam logic [VW-1:0]     IMG_YS    = VW'(IMG_Y0);
   localparam logic [VW-1:0]     IMG_YE    = VW'(IMG_Y0 + IMG_H);
   localparam logic [ADDR_W-1:0] ADDR_MAX  = ADDR_W'(IMG_W * IMG_H / 8 - 1);
   localparam logic [3:0]        RPT_LAST  = 4'(FRAME_REPEAT - 1);

   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;
   state_t        state;
   logic [3:0]    repeat_cnt;

   logic          h_last, frame_start, frame_last, active_end_next;
   logic          in_img, hs_now, vs_now;
   logic [2:0]    x_phase;

   logic          img_d1, hs_d1, vs_d1;
   logic [2:0]    phase_d1;
   logic [7:0]    word_sel;
   logic          pix_bit;
   logic [3:0]    rgb_q;

   always_comb begin
      h_last          = (h_cnt == H_LAST);
      frame_start     = (h_cnt == '0) && (v_cnt == '0);
      frame_last      = h_last && (v_cnt == V_LAST);
      // one cycle ahead of h=0 on the first line after active video
      active_end_next = h_last && (v_cnt == V_ACT_END);
      in_img          = (h_cnt >= IMG_XS) && (h_cnt < IMG_XE) &&
                        (v_cnt >= IMG_YS) && (v_cnt < IMG_YE);
      hs_now          = (h_cnt >= H_SYNC_S) && (h_cnt < H_SYNC_E);
      vs_now          = (v_cnt >= V_SYNC_S) && (v_cnt < V_SYNC_E);
      x_phase         = h_cnt[2:0] - IMG_XS[2:0];
   end

   // Horizontal and vertical timing counters
   always_ff @(posedge CLK_40 or negedge reset) begin
      if (!reset) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_last) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
      end else begin
         h_cnt <= h_cnt + HW'(1);
      end
   end

   // Running word address: steps after each 8th image pixel, saturates, clears at frame wrap
   always_ff @(posedge CLK_40 or negedge reset) begin
      if (!reset) begin
         rd_addr <= '0;
      end else if (frame_last) begin
         rd_addr <= '0;
      end else if (in_img && (x_phase == 3'd7) && (rd_addr != ADDR_MAX)) begin
         rd_addr <= rd_addr + ADDR_W'(1);
      end
   end

   // Stage 1: carry pixel position and sync alongside the RAM read
   always_ff @(posedge CLK_40 or negedge reset) begin
      if (!reset) begin
         img_d1   <= 1'b0;
         hs_d1    <= 1'b0;
         vs_d1    <= 1'b0;
         phase_d1 <= 3'd0;
      end else begin
         img_d1   <= in_img;
         hs_d1    <= hs_now;
         vs_d1    <= vs_now;
         phase_d1 <= x_phase;
      end
   end

   always_comb begin
      word_sel = 8'h00;
      case (state)
         SHOW1:   word_sel = rd_data1;
         SHOW2:   word_sel = rd_data2;
         default: word_sel = 8'h00;
      endcase
      pix_bit = word_sel[3'd7 - phase_d1];
   end

   // Stage 2: register colour and sync onto the pins
   always_ff @(posedge CLK_40 or negedge reset) begin
      if (!reset) begin
         hsync <= 1'b0;
         vsync <= 1'b0;
         rgb_q <= 4'h0;
      end else begin
         hsync <= hs_d1;
         vsync <= vs_d1;
         rgb_q <= {4{img_d1 & pix_bit}};
      end
   end

   assign vga_r = rgb_q;
   assign vga_g = rgb_q;
   assign vga_b = rgb_q;

   // Bank latch: choose a bank at frame start, count refreshes, pulse done after the last one
   always_ff @(posedge CLK_40 or negedge reset) begin
      if (!reset) begin
         state           <= IDLE;
         repeat_cnt      <= 4'd0;
         bank1_read_done <= 1'b0;
         bank2_read_done <= 1'b0;
      end else begin
         bank1_read_done <= 1'b0;
         bank2_read_done <= 1'b0;
         case (state)
            IDLE: begin
               if (frame_start) begin
                  repeat_cnt <= 4'd0;
                  if (read_bank1) begin
                     state <= SHOW1;
                  end else if (read_bank2) begin
                     state <= SHOW2;
                  end
               end
            end
            SHOW1, SHOW2: begin
               if (active_end_next) begin
                  if (repeat_cnt == RPT_LAST) begin
                     bank1_read_done <= (state == SHOW1);
                     bank2_read_done <= (state == SHOW2);
                     repeat_cnt      <= 4'd0;
                     state           <= IDLE;
                  end else begin
                     repeat_cnt <= repeat_cnt + 4'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/video_bank_reader.md
Name: video_bank_reader

Overview:
- Display-side reader of the ping-pong video banks filled by the video bank write path.
- Generates 800x600@60 VGA timing from the 40 MHz clock and fetches 1bpp packed pixel words from the bank selected by read_bank1/read_bank2.
- Draws the frame centred in the active area and returns a one-cycle done pulse per bank so the mode FSM can swap banks.

Parameters:
- IMG_W, 480, image width in pixels; multiple of 8
- IMG_H, 360, image height in lines
- IMG_X0, 160, first image column in the active area
- IMG_Y0, 120, first image line in the active area
- FRAME_REPEAT, 2, display refreshes per bank before done; 1..15
- ADDR_W, 15, read address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H/8

Ports:
- CLK_40  in  1  40 MHz pixel clock
- reset  in  1  asynchronous, active-low reset
- read_bank1  in  1  bank 1 is readable (from mode FSM)
- read_bank2  in  1  bank 2 is readable (from mode FSM)
- rd_addr  out  ADDR_W  word address to both bank buffers
- rd_data1  in  8  bank 1 word; synchronous RAM, valid 1 cycle after rd_addr
- rd_data2  in  8  bank 2 word; same timing
- hsync  out  1  horizontal sync, active-high
- vsync  out  1  vertical sync, active-high
- vga_r, vga_g, vga_b  out  4 each  colour; all 4'hF for pixel 1, 0 otherwise
- bank1_read_done  out  1  one-cycle pulse: bank 1 fully displayed
- bank2_read_done  out  1  one-cycle pulse: bank 2 fully displayed

Behaviour:
- Reset (reset=0, async) clears all state and forces outputs to 0: hsync, vsync, rgb, rd_addr, both done outputs, h/v counters, repeat counter, latched bank = NONE. Reset is honoured mid-frame; timing restarts at h=0, v=0 after release.
- Timing counters:
  - h counts 0..1055: active 0..799, front porch 800..839, sync 840..967, back porch 968..1055.
  - v advances when h wraps and counts 0..627: active 0..599, front porch 600, sync 601..604, back porch 605..627.
  - One frame = 663,168 cycles.
- Pipeline, stage 0 (counters, address):
  - In-image: IMG_X0 <= h < IMG_X0+IMG_W and IMG_Y0 <= v < IMG_Y0+IMG_H.
  - rd_addr increments by 1 after each in-image h with (h-IMG_X0)%8==7. It is a running word counter, so row stride is implicit.
  - rd_addr resets to 0 at frame start (h=0, v=0).
- Pipeline, stage 1: RAM returns the word; the latched bank's data is selected.
- Pipeline, stage 2: pixel = word bit [7-((h-IMG_X0)%8)], MSB leftmost.
- Outputs: hsync, vsync and the in-image flag are each delayed 2 cycles so colour aligns with sync. Fixed latency from counter to pins is 2 cycles. Outside the image or outside active, rgb=0.
- Bank latch FSM:
  - States IDLE, SHOW1, SHOW2, evaluated only at frame start.
  - IDLE: read_bank1 -> SHOW1, repeat=0; else read_bank2 -> SHOW2; else stay IDLE and show a black frame. Both inputs high -> bank 1 wins.
  - SHOWn: repeat++ at each frame end. When repeat reaches FRAME_REPEAT, pulse bankn_read_done for exactly one cycle at h=0, v=600, then go to IDLE. The next frame start re-evaluates inputs.
- read_bank inputs changing mid-frame are ignored until the next frame start.
- Done pulses never overlap; at most one per FRAME_REPEAT frames.
- An input dropping while in SHOWn does not abort the display; done still fires.
- rd_addr tops out at IMG_W*IMG_H/8-1 = 21599 with defaults, then holds until frame start.

Test Plan:
- Reset values: hold reset=0 for 10 cycles -> every output 0. Release, then count 1056 cycles between hsync rises, 663,168 cycles between vsync rises, and hsync high for 128 cycles.
- Bank 1 pattern: read_bank1=1 and RAM1 word k = 8'hA5 -> at pixel pins, line v=120 h=160..167 gives rgb pattern 1,0,1,0,0,1,0,1. rd_addr=0 is presented 2 cycles before h=160 appears. rgb=0 at h=159 and h=640.
- Address sweep: full image frame -> rd_addr takes 0..21599 in order, each value held 8 cycles, and is 0 again at the next frame start.
- Done timing: FRAME_REPEAT=2, read_bank1=1 -> bank1_read_done single-cycle pulse at h=0, v=600 of the 2nd frame; bank2_read_done stays 0.
- Swap and priority: flip read_bank1->0 and read_bank2->1 mid-frame -> bank 1 data kept until its done. With both inputs high at frame start -> SHOW1. With neither high -> black frame and no done pulse.
- Reset mid-frame: assert reset at v=300 -> outputs 0 immediately (asynchronous). After release, the first vsync rises after 601 lines and the FSM is IDLE.
